serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/fadd_bit.sv | 21 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fadd_bit.sv
// One-bit full adder: two half-adder stages with the stage carries ORed together.
// Purely combinational; the serial adder uses a single instance of it.
module fadd_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  assign s1  = a_i ^ b_i;
  assign c1  = a_i & b_i;
  assign s_o = s1 ^ c_i;
  assign c2  = s1 & c_i;
  assign c_o = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full-adder cell, WIDTH shift cycles per addition.
// sum/cout are separate holding registers, so partial results never reach the outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_cat;

  fadd_bit u_fadd (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // The result register only needs WIDTH-1 bits: the final sum bit goes straight into sum_q.
  assign res_cat  = {fa_s, res_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          res_q   <= res_cat[WIDTH-1:1];
          if (last_bit) begin
            sum_q  <= res_cat;
            cout_q <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed WIDTH=8 scenarios plus randomised WIDTH=4 and WIDTH=16 runs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_adder;

  logic clk;
  logic rst;

  logic        start8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
  logic        start16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  logic [8:0]  exp8_q[$];
  logic [4:0]  exp4_q[$];
  logic [16:0] exp16_q[$];
  logic [8:0]  last8;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 addition. Operands are scrambled while the operation runs; restart_at
  // re-asserts start (with inverted operands) at that sample to prove it is ignored.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int restart_at);
    logic [8:0] e;
    exp8_q.push_back({1'b0, av} + {1'b0, bv});
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("busy8_shift", busy8, 1);
      check("done8_shift", done8, 0);
      check("sum8_held_shift", {cout8, sum8}, last8);
      if (i == restart_at) begin
        start8 = 1'b1; a8 = ~av; b8 = ~bv;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("done8", done8, 1);
    check("busy8_done", busy8, 0);
    check("sb8_nonempty", exp8_q.size() != 0, 1);
    if (exp8_q.size() != 0) begin
      e = exp8_q.pop_front();
      check("result8", {cout8, sum8}, e);
      last8 = e;
    end
    @(negedge clk);
    check("done8_pulse", done8, 0);
    check("busy8_idle", busy8, 0);
    check("result8_hold", {cout8, sum8}, last8);
  endtask

  initial begin
    logic [8:0]  e8;
    logic [3:0]  av4, bv4;
    logic [15:0] av16, bv16;
    int cyc, pulses, last_t, seen, t;

    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0;
    start4 = 0; a4 = '0; b4 = '0;
    start16 = 0; a16 = '0; b16 = '0;
    last8 = '0;
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_result8", {cout8, sum8}, 0);
    check("rst_result4", {busy4, done4, cout4, sum4}, 0);
    check("rst_result16", {busy16, done16, cout16, sum16}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op8(8'h35, 8'h4A, -1);
    op8(8'hFF, 8'h01, -1);
    repeat (5) begin
      @(negedge clk);
      check("wrap_hold", {busy8, done8, cout8, sum8}, {2'b00, 9'h100});
    end
    op8(8'h10, 8'h20, 4);
    repeat (4) begin
      @(negedge clk);
      check("no_second_op", {busy8, done8}, 0);
    end

    // Reset part-way through an operation.
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy8, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_result", {cout8, sum8}, 0);
    @(negedge clk);
    rst = 1'b0;
    last8 = '0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check("no_done_after_rst", seen, 0);
    check("sb8_empty_after_rst", exp8_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op8(8'h01, 8'h02, -1);

    // start held high: back-to-back additions every WIDTH+2 cycles.
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    repeat (3) exp8_q.push_back(9'h100);
    cyc = 0; pulses = 0; last_t = 0;
    while (pulses < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (pulses == 0) check("b2b_first_latency", cyc, 9);
        else             check("b2b_gap", cyc - last_t, 10);
        last_t = cyc;
        pulses++;
        if (exp8_q.size() != 0) begin
          e8 = exp8_q.pop_front();
          check("b2b_result", {cout8, sum8}, e8);
        end
        if (pulses == 3) start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check("b2b_pulses", pulses, 3);
    @(negedge clk);
    check("b2b_idle", busy8, 0);

    for (int n = 0; n < 1000; n++) begin
      av4 = 4'($urandom_range(0, 15));
      bv4 = 4'($urandom_range(0, 15));
      exp4_q.push_back({1'b0, av4} + {1'b0, bv4});
      a4 = av4; b4 = bv4; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      t = 0;
      while (done4 !== 1'b1 && t < 12) begin
        @(negedge clk);
        t++;
      end
      check("lat4", t, 4);
      if (done4 === 1'b1 && exp4_q.size() != 0) check("result4", {cout4, sum4}, exp4_q.pop_front());
      @(negedge clk);
    end

    for (int n = 0; n < 1000; n++) begin
      av16 = 16'($urandom_range(0, 65535));
      bv16 = 16'($urandom_range(0, 65535));
      exp16_q.push_back({1'b0, av16} + {1'b0, bv16});
      a16 = av16; b16 = bv16; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
      t = 0;
      while (done16 !== 1'b1 && t < 24) begin
        @(negedge clk);
        t++;
      end
      check("lat16", t, 16);
      if (done16 === 1'b1 && exp16_q.size() != 0) check("result16", {cout16, sum16}, exp16_q.pop_front());
      @(negedge clk);
    end

    check("sb_all_drained", exp8_q.size() + exp4_q.size() + exp16_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
